// File: rtl/crc32_16_frame_ctrl.sv
// Frame sequencer around a 16-bit-per-cycle CRC-32 (poly 0x04C11DB7, MSB first).
// Accepts words on a valid/ready stream, finalizes an optional odd trailing
// byte, and presents one held result (CRC, byte count, residue check) per frame.
//
// state | meaning
// IDLE  | waiting for the first word of a frame; crc_q holds INIT, len_q holds 0
// RUN   | mid-frame; crc_q/len_q hold the running register and byte count
// DONE  | result presented on res_*; input stalled until the result is taken
module crc32_16_frame_ctrl #(
  parameter logic [31:0] INIT    = 32'hFFFF_FFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFF_FFFF,
  parameter logic [31:0] RESIDUE = 32'hC704_DD7B
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        abort_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [15:0] s_data_i,
  input  logic        s_last_i,
  input  logic [1:0]  s_be_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_crc_o,
  output logic        res_ok_o,
  output logic [15:0] res_len_o
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] len_q, len_d;
  logic        ready_d;
  logic        load_res;
  logic        accept;
  logic        handshake;
  logic [31:0] crc_base;
  logic [15:0] len_base;
  logic [31:0] crc_full;
  logic [31:0] crc_half;
  logic [1:0]  add_bytes;
  logic [16:0] len_sum;

  function automatic logic [31:0] step16(input logic [31:0] crc, input logic [15:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 16; i++) begin
      fb = c[31] ^ data[15-i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return c;
  endfunction

  function automatic logic [31:0] step8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data[7-i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return c;
  endfunction

  assign accept    = s_valid_i & s_ready_o;
  assign handshake = res_valid_o & res_ready_i;

  // A frame always starts from the seed, even if crc_q was left untouched.
  assign crc_base = (state_q == IDLE) ? INIT : crc_q;
  assign len_base = (state_q == IDLE) ? 16'h0 : len_q;
  assign crc_full = step16(crc_base, s_data_i);
  assign crc_half = step8(crc_base, s_data_i[15:8]);

  // Next-state, register update and result-load decision.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    load_res  = 1'b0;
    add_bytes = 2'd0;
    len_sum   = 17'h0;
    case (state_q)
      IDLE, RUN: begin
        if (abort_i) begin
          crc_d   = INIT;
          len_d   = 16'h0;
          state_d = IDLE;
        end else if (accept) begin
          if (!s_last_i || s_be_i == 2'b11) begin
            crc_d     = crc_full;
            add_bytes = 2'd2;
          end else if (s_be_i == 2'b10) begin
            crc_d     = crc_half;
            add_bytes = 2'd1;
          end else begin
            // be=00, and the illegal be=01, carry no data bytes.
            crc_d     = crc_base;
            add_bytes = 2'd0;
          end
          len_sum  = {1'b0, len_base} + {15'h0, add_bytes};
          len_d    = len_sum[16] ? 16'hFFFF : len_sum[15:0];
          state_d  = s_last_i ? DONE : RUN;
          load_res = s_last_i;
        end
      end
      DONE: begin
        if (handshake) begin
          crc_d   = INIT;
          len_d   = 16'h0;
          state_d = IDLE;
        end
      end
      default: begin
        crc_d   = INIT;
        len_d   = 16'h0;
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d != DONE);
  end

  // State, running CRC/length and registered input ready.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      len_q     <= 16'h0;
      s_ready_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      s_ready_o <= ready_d;
    end
  end

  // Result registers: loaded on the last-word accept, held until handshake.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_valid_o <= 1'b0;
      res_crc_o   <= 32'h0;
      res_ok_o    <= 1'b0;
      res_len_o   <= 16'h0;
    end else if (load_res) begin
      res_valid_o <= 1'b1;
      res_crc_o   <= crc_d ^ XOR_OUT;
      res_ok_o    <= (crc_d == RESIDUE);
      res_len_o   <= len_d;
    end else if (handshake) begin
      res_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crc32_16_frame_ctrl.sv
// Bench for crc32_16_frame_ctrl: directed vector table, hand-written abort/reset
// sequences, and random frames checked against a byte-serial CRC reference.
module tb_crc32_16_frame_ctrl;

  localparam logic [31:0] INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] RESIDUE = 32'hC704_DD7B;
  localparam logic [31:0] POLY    = 32'h04C1_1DB7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = 16'h0;
  logic        s_last = 1'b0;
  logic [1:0]  s_be = 2'b00;
  logic        res_ready = 1'b0;

  logic        s_ready, res_valid, res_ok;
  logic [31:0] res_crc;
  logic [15:0] res_len;
  logic        x0_s_ready, x0_res_valid, x0_res_ok;
  logic [31:0] x0_res_crc;
  logic [15:0] x0_res_len;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] fw[$];

  typedef struct {
    int              n;
    logic [1:0]      be;
    bit              chk;
    logic [31:0]     crc;
    logic [15:0]     len;
    bit              ok;
    int              hold;
    bit              junk;
    logic [6:0][15:0] w;
  } vec_t;

  vec_t vecs[6];

  crc32_16_frame_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .abort_i(abort),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .s_last_i(s_last), .s_be_i(s_be),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_crc_o(res_crc), .res_ok_o(res_ok), .res_len_o(res_len)
  );

  crc32_16_frame_ctrl #(.XOR_OUT(32'h0)) dut_x0 (
    .clk_i(clk), .rst_n_i(rst_n), .abort_i(abort),
    .s_valid_i(s_valid), .s_ready_o(x0_s_ready), .s_data_i(s_data),
    .s_last_i(s_last), .s_be_i(s_be),
    .res_valid_o(x0_res_valid), .res_ready_i(res_ready),
    .res_crc_o(x0_res_crc), .res_ok_o(x0_res_ok), .res_len_o(x0_res_len)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", compared, mismatched);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [1:0] be, input bit c,
                              input logic [31:0] crc, input logic [15:0] len, input bit ok,
                              input int hold, input bit junk,
                              input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                              input logic [15:0] w3, input logic [15:0] w4, input logic [15:0] w5,
                              input logic [15:0] w6);
    vec_t v;
    v.n = n; v.be = be; v.chk = c; v.crc = crc; v.len = len; v.ok = ok;
    v.hold = hold; v.junk = junk;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.w[4] = w4; v.w[5] = w5; v.w[6] = w6;
    return v;
  endfunction

  // Reference: byte-serial CRC over the bytes the frame actually carries.
  task automatic model(input logic [1:0] be, output logic [31:0] raw, output logic [15:0] len);
    logic [31:0] c;
    logic [7:0]  b;
    int          cnt;
    int          nb;
    c   = INIT;
    cnt = 0;
    for (int i = 0; i < fw.size(); i++) begin
      if (i < fw.size() - 1) nb = 2;
      else if (be == 2'b11) nb = 2;
      else if (be == 2'b10) nb = 1;
      else nb = 0;
      for (int j = 0; j < nb; j++) begin
        b = (j == 0) ? fw[i][15:8] : fw[i][7:0];
        c = c ^ {b, 24'h0};
        for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
        cnt++;
      end
    end
    raw = c;
    len = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
  endtask

  task automatic put_word(input logic [15:0] d, input bit last, input logic [1:0] be);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_last = last; s_be = be;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("put_word_timeout", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic run_frame(input logic [1:0] be, input int hold, input bit junk, input bit abort_done,
                           output logic [31:0] crc, output logic [31:0] x0crc,
                           output logic [15:0] len, output logic ok);
    for (int i = 0; i < fw.size(); i++) put_word(fw[i], (i == fw.size() - 1), be);
    chk("res_latency", 32'(res_valid), 32'd1);
    crc = res_crc; x0crc = x0_res_crc; len = res_len; ok = res_ok;
    if (abort_done) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_done_valid", 32'(res_valid), 32'd1);
      chk("abort_done_crc", res_crc, crc);
      chk("abort_done_len", 32'(res_len), 32'(len));
    end
    for (int h = 0; h < hold; h++) begin
      if (junk) begin
        s_valid = 1'b1; s_data = 16'hA5A5; s_last = 1'b0;
      end
      @(posedge clk); #1;
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_crc", res_crc, crc);
      chk("hold_len", 32'(res_len), 32'(len));
      chk("hold_ok", 32'(res_ok), 32'(ok));
      chk("hold_s_ready", 32'(s_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0; s_valid = 1'b0;
    chk("post_hs_valid", 32'(res_valid), 32'd0);
    chk("post_hs_s_ready", 32'(s_ready), 32'd1);
  endtask

  task automatic frame_vs_model(input string tag, input logic [1:0] be, input int hold,
                                input bit junk, input bit abort_done);
    logic [31:0] crc, x0crc, raw;
    logic [15:0] len, mlen;
    logic        ok;
    run_frame(be, hold, junk, abort_done, crc, x0crc, len, ok);
    model(be, raw, mlen);
    chk({tag, "_crc"}, crc, raw ^ 32'hFFFF_FFFF);
    chk({tag, "_x0crc"}, x0crc, raw);
    chk({tag, "_len"}, 32'(len), 32'(mlen));
    chk({tag, "_ok"}, 32'(ok), 32'(raw == RESIDUE));
  endtask

  task automatic load_vec(input int v);
    fw.delete();
    for (int i = 0; i < vecs[v].n; i++) fw.push_back(vecs[v].w[i]);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_crc"}, res_crc, 32'd0);
    chk({tag, "_res_ok"}, 32'(res_ok), 32'd0);
    chk({tag, "_res_len"}, 32'(res_len), 32'd0);
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready_low", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_release_ready_high", 32'(s_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] crc, x0crc;
    logic [15:0] len;
    logic        ok;

    vecs[0] = mk(5, 2'b10, 1, 32'hFC89_1918, 16'd9, 0, 5, 1,
                 16'h3132, 16'h3334, 16'h3536, 16'h3738, 16'h3900, 16'h0, 16'h0);
    vecs[1] = mk(7, 2'b10, 1, 32'h38FB_2284, 16'd13, 1, 0, 0,
                 16'h3132, 16'h3334, 16'h3536, 16'h3738, 16'h39FC, 16'h8919, 16'h1800);
    vecs[2] = mk(7, 2'b10, 0, 32'h0, 16'd13, 0, 1, 0,
                 16'h3132, 16'h3334, 16'h3537, 16'h3738, 16'h39FC, 16'h8919, 16'h1800);
    vecs[3] = mk(1, 2'b00, 1, 32'h0000_0000, 16'd0, 0, 2, 0,
                 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[4] = mk(2, 2'b01, 0, 32'h0, 16'd2, 0, 0, 0,
                 16'h3132, 16'hBEEF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[5] = mk(5, 2'b11, 0, 32'h0, 16'd10, 0, 3, 1,
                 16'h3132, 16'h3334, 16'h3536, 16'h3738, 16'h3938, 16'h0, 16'h0);

    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset_release();

    // Directed vector table.
    for (int v = 0; v < 6; v++) begin
      load_vec(v);
      run_frame(vecs[v].be, vecs[v].hold, vecs[v].junk, 1'b0, crc, x0crc, len, ok);
      chk($sformatf("vec%0d_len", v), 32'(len), 32'(vecs[v].len));
      chk($sformatf("vec%0d_ok", v), 32'(ok), 32'(vecs[v].ok));
      if (vecs[v].chk) chk($sformatf("vec%0d_crc", v), crc, vecs[v].crc);
      if (vecs[v].be == 2'b00) chk($sformatf("vec%0d_x0_empty", v), x0crc, 32'hFFFF_FFFF);
      load_vec(v);
      frame_vs_model($sformatf("vec%0d_model", v), vecs[v].be, 0, 1'b0, 1'b0);
    end

    // Abort mid-frame with a word presented the same cycle.
    put_word(16'h3132, 1'b0, 2'b11);
    put_word(16'h3334, 1'b0, 2'b11);
    s_valid = 1'b1; s_data = 16'h3536; s_last = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; s_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_no_result", 32'(res_valid), 32'd0);
    chk("abort_ready", 32'(s_ready), 32'd1);
    load_vec(0);
    run_frame(2'b10, 0, 1'b0, 1'b0, crc, x0crc, len, ok);
    chk("after_abort_crc", crc, 32'hFC89_1918);
    chk("after_abort_len", 32'(len), 32'd9);

    // Abort pulsed while the result is pending.
    load_vec(0);
    run_frame(2'b10, 2, 1'b0, 1'b1, crc, x0crc, len, ok);
    chk("abort_in_done_crc", crc, 32'hFC89_1918);
    chk("abort_in_done_len", 32'(len), 32'd9);

    // Async reset mid-frame.
    put_word(16'h3132, 1'b0, 2'b11);
    put_word(16'h3334, 1'b0, 2'b11);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_midframe");
    reset_release();
    load_vec(0);
    run_frame(2'b10, 0, 1'b0, 1'b0, crc, x0crc, len, ok);
    chk("after_rst_mid_crc", crc, 32'hFC89_1918);
    chk("after_rst_mid_len", 32'(len), 32'd9);

    // Async reset while the result is valid.
    for (int i = 0; i < 5; i++) put_word(vecs[0].w[i], (i == 4), 2'b10);
    chk("rst_done_pre_valid", 32'(res_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_done");
    reset_release();
    load_vec(0);
    run_frame(2'b10, 1, 1'b1, 1'b0, crc, x0crc, len, ok);
    chk("after_rst_done_crc", crc, 32'hFC89_1918);
    chk("after_rst_done_len", 32'(len), 32'd9);

    // Random frames against the reference model.
    for (int f = 0; f < 25; f++) begin
      int n;
      n = int'($urandom_range(1, 8));
      fw.delete();
      for (int i = 0; i < n; i++) fw.push_back(16'($urandom));
      frame_vs_model($sformatf("rand%0d", f), 2'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 3) == 0));
      repeat (int'($urandom_range(0, 2))) begin @(posedge clk); #1; end
    end

    // Length saturation: 65538 bytes reports 16'hFFFF, CRC keeps running.
    fw.delete();
    for (int i = 0; i < 32769; i++) fw.push_back(16'($urandom));
    frame_vs_model("saturate", 2'b11, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/crc32_16_frame_ctrl.md
Name: crc32_16_frame_ctrl

Overview:
Frame-level sequencer around the 16-bit-per-cycle CRC-32 step: polynomial 0x4C11DB7, left-shifting (MSB first), data_i[15] is the first bit on the wire.
- Accepts a stream of 16-bit words with valid/ready and a last flag.
- Seeds, advances and finalizes the CRC register, including an odd trailing byte.
- Presents one result per frame (CRC, byte count, residue check) on a held output handshake.
- Sits between a packet source (MAC/DMA framer) and the frame checker/inserter.

Parameters:
INIT, 32'hFFFFFFFF, CRC register seed loaded at start of every frame.
XOR_OUT, 32'hFFFFFFFF, value XORed into the register to form res_crc_o.
RESIDUE, 32'hC704DD7B, expected raw register (before XOR_OUT) after a frame that includes its own CRC.

Ports:
clk_i  in  1  clock, all logic on rising edge.
rst_n_i  in  1  asynchronous active-low reset.
abort_i  in  1  synchronous frame abort.
s_valid_i  in  1  input word valid.
s_ready_o  out  1  input word accepted when s_valid_i&s_ready_o.
s_data_i  in  16  input word; [15:8] is the first byte.
s_last_i  in  1  final word of frame.
s_be_i  in  2  byte enables, sampled only with s_last_i: 11 both bytes, 10 high byte only, 00 no bytes; 01 illegal (treat as 00).
res_valid_o  out  1  result valid.
res_ready_i  in  1  result consumed when res_valid_o&res_ready_i.
res_crc_o  out  32  final CRC = raw register ^ XOR_OUT.
res_ok_o  out  1  raw register == RESIDUE.
res_len_o  out  16  bytes consumed in frame, saturating at 16'hFFFF.

Behaviour:
- Reset (async, rst_n_i low):
  - state=IDLE, crc_q=INIT, len_q=0.
  - s_ready_o=0, res_valid_o=0, res_crc_o=0, res_ok_o=0, res_len_o=0.
  - s_ready_o rises the first cycle after reset deasserts.
- States: IDLE, RUN, DONE. s_ready_o=1 in IDLE and RUN, 0 in DONE.
- Word accept (IDLE or RUN), register update:
  - Full word: crc_q <= step16(crc_q, s_data_i). If the state is IDLE, use INIT as the crc_q operand instead (crc_q is already INIT after reset/result).
  - Last with be=10: crc_q <= step8(crc, s_data_i[15:8]); step8 is the same polynomial, 8 bits MSB first.
  - Last with be=00: crc_q unchanged.
  - len_q += 2, 1 or 0 accordingly, saturating.
- State on word accept:
  - Not last: state -> RUN.
  - Last: state -> DONE. Next cycle res_valid_o=1 with res_crc_o, res_ok_o, res_len_o computed from the updated register and count. Latency is 1 cycle from the last-word accept edge.
- DONE:
  - Outputs held stable while res_valid_o=1 and res_ready_i=0.
  - On handshake: res_valid_o<=0, crc_q<=INIT, len_q<=0, state->IDLE.
  - s_ready_o rises the cycle after the handshake. No input is accepted in the handshake cycle, giving 1 bubble per frame.
- abort_i=1 in IDLE/RUN:
  - crc_q<=INIT, len_q<=0, state->IDLE.
  - Any word presented that cycle is dropped; no result is produced.
- abort_i in DONE: ignored; the pending result must still be consumed.
- abort_i has priority over a simultaneous word accept.
- Single-word frame (last on first word): IDLE->DONE directly.
- Empty frame (last, be=00, first word): res_crc_o = INIT^XOR_OUT, res_len_o=0.
- Length saturation: len stays 16'hFFFF; CRC continues normally.
- Reset mid-frame or mid-DONE returns to reset values immediately; partial frame is lost.
- res_ok_o is computed on the raw register, independent of XOR_OUT.

Test Plan:
- Bytes "123456789" as words 3132,3334,3536,3738 then 3900 with last, be=10, back-to-back valid -> one cycle after last accept: res_valid_o=1, res_crc_o=32'hFC891918, res_len_o=9, res_ok_o=0.
- Same frame followed by its CRC: words 3132,3334,3536,3738,39FC,8919, then 1800 with last, be=10 -> res_len_o=13, res_ok_o=1. Flip data bit 0 of word 2 -> res_ok_o=0.
- Empty frame: single word, last, be=00 -> res_crc_o=32'h00000000, res_len_o=0. With XOR_OUT=0 override -> res_crc_o=32'hFFFFFFFF.
- Backpressure: hold res_ready_i=0 for 5 cycles after the result -> outputs stable, s_ready_o=0 throughout, valid input words not accepted. Release -> s_ready_o=1 next cycle; second "123456789" frame gives FC891918 again (INIT reseeded).
- Abort: send 3132,3334, assert abort_i with 3536 valid -> no result. Then send the full "123456789" frame -> FC891918, len 9. abort_i pulsed in DONE -> result unchanged, still delivered.
- Async reset asserted mid-frame and while res_valid_o=1 -> all outputs 0 immediately; after release, "123456789" frame -> FC891918.
